sseg_display_ctrl: RTL and testbench
====================================

Name: sseg_display_ctrl

Overview:
Sequencing controller that converts a signed binary value into per-digit drive for a bank of NUM_DIGITS seven-segment encoder instances. Each encoder instance takes a 4-bit digit, a negative-sign select and an enable. The block runs a multi-cycle serial binary-to-BCD conversion for decimal mode, or a direct nibble split for hex mode. It then applies leading-zero blanking, places the minus sign and flags overflow. It sits between datapath result registers and the display encoders.

Parameters:
NUM_DIGITS, 4, number of display digits driven (1..8)
WIDTH, 12, width of the input value in bits; two's-complement in decimal mode (2..16)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to format value; sampled only in IDLE
mode_dec  in  1  1 = signed decimal, 0 = unsigned hex
value  in  WIDTH  value to display, captured on the accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; display outputs update in this same cycle
ovf  out  1  last result did not fit the display
dig_bin  out  4*NUM_DIGITS  digit i occupies [4i+3:4i]; digit 0 is rightmost
dig_neg  out  NUM_DIGITS  per-digit minus-sign select
dig_en  out  NUM_DIGITS  per-digit enable; 0 = blank

Behaviour:
- Single clock domain (clk); reset is asynchronous and active-low (rst_n). All state flops are reset directly by rst_n.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, dig_bin=0, dig_neg=0, dig_en=0 (all digits blank).
- States: IDLE, CONV, FMT.
- IDLE: when start=1, capture mode_dec and value, then go to CONV (decimal) or FMT (hex).
  - Decimal capture: magnitude = |value| as an unsigned WIDTH-bit number (-2^(WIDTH-1) maps to 2^(WIDTH-1)); sign = value[WIDTH-1].
- CONV: shift-add-3 double-dabble, one magnitude bit per cycle, MSB first, for exactly WIDTH cycles, then go to FMT.
  - Internal BCD width = enough digits for 2^(WIDTH-1) (e.g. 4 digits for WIDTH=12).
- FMT: one cycle. Compute the registered digit outputs, ovf and done, then return to IDLE.
- Latency, counted from the clock edge that samples start:
  - hex: done=1 in cycle 2.
  - decimal: done=1 in cycle WIDTH+2.
- busy=1 in every CONV/FMT cycle. busy is 0 in the done cycle. A new start may be accepted in the done cycle.
- start while busy is ignored, not queued. value may change freely after acceptance.
- dig_* and ovf hold their previous values throughout a conversion, so the display does not flicker.
- Significant digit count s = index of the highest nonzero digit + 1. s=1 when the value is zero.
- Hex digits are the nibbles of value, zero-extended to a multiple of 4 bits. Hex never shows a sign.
- Formatting:
  - Digits 0..s-1 are enabled with dig_bin set and dig_neg=0.
  - If decimal and negative, digit s gets dig_en=1 and dig_neg=1.
  - All higher digits get dig_en=0 and dig_bin=0.
- Overflow: set when s > NUM_DIGITS, or when the value is negative and s = NUM_DIGITS.
  - On overflow: ovf=1, dig_en all 1, dig_neg all 1, dig_bin=0 (dashes across every digit).
  - Otherwise ovf=0.
- rst_n asserted mid-conversion: abort immediately to reset values. No done pulse is produced.

Decomposition:
- Package sseg_ctrl_pkg holds:
  - the state enum (IDLE, CONV, FMT);
  - constant functions BCD_DIGITS(WIDTH) and HEX_DIGITS(WIDTH);
  - localparams for the bit-count counter width.
- One sub-module, sseg_bin2bcd_serial: load/shift/add-3 datapath with a bit counter and a last_bit flag, controlled by the FSM here.
- Blanking, sign placement and overflow logic stay in this module.

Test Plan (NUM_DIGITS=4, WIDTH=12):
- Reset with no start -> busy=0, done=0, ovf=0, dig_en=0000, dig_neg=0000; start pulse during reset has no effect.
- Decimal 123 -> done exactly 14 cycles after start; dig_en=0111, dig_bin=0x0123, dig_neg=0000, ovf=0.
- Decimal -45 -> dig_en=0111, dig_neg=0100, digits 1,0 = 4,5; decimal -999 -> dig_en=1111, dig_neg=1000; decimal 2047 -> dig_en=1111, dig_bin=0x2047.
- Decimal -2048 -> ovf=1, dig_en=1111, dig_neg=1111; a following decimal 0 -> ovf=0, dig_en=0001, dig_bin=0x0000.
- Hex 0xABC -> done 2 cycles after start; dig_en=0111, dig_bin=0x0ABC, dig_neg=0000. A start asserted while busy is ignored: exactly one done pulse occurs, and it shows the first value.
- Display showing 123; accept start for 456, then assert rst_n=0 at cycle 5 -> all outputs blank immediately; after release, busy=0 and no done pulse.

Source files
------------

// File: rtl/sseg_ctrl_pkg.sv
// rtl/sseg_ctrl_pkg.sv - shared types and sizing helpers for the seven-segment display controller
package sseg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 16;
    // Bit counter only has to reach WIDTH-1, so MAX_WIDTH-1 sets its size.
    localparam int CNT_W     = $clog2(MAX_WIDTH);

    // Decimal digits needed to hold 2^(width-1), the largest magnitude of a signed value.
    function automatic int BCD_DIGITS(input int width);
        int v;
        int n;
        v = 1 << (width - 1);
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic int HEX_DIGITS(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/sseg_bin2bcd_serial.sv
// rtl/sseg_bin2bcd_serial.sv - serial double-dabble converter, one input bit per shift cycle
module sseg_bin2bcd_serial
    import sseg_ctrl_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int BD    = BCD_DIGITS(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WIDTH-1:0]  bin_in,
    output logic [4*BD-1:0]   bcd,
    output logic              last_bit
);

    logic [WIDTH-1:0] sr_q;
    logic [4*BD-1:0]  bcd_q;
    logic [4*BD-1:0]  adj;
    logic [CNT_W-1:0] cnt_q;

    // Add 3 to every digit of 5 or more so the following left shift carries correctly.
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < BD; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= bin_in;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (shift) begin
            sr_q  <= sr_q << 1;
            bcd_q <= {adj[4*BD-2:0], sr_q[WIDTH-1]};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bcd      = bcd_q;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sseg_display_ctrl.sv
// rtl/sseg_display_ctrl.sv - formats a signed decimal or hex value into per-digit seven-segment drive
module sseg_display_ctrl
    import sseg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode_dec,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [4*NUM_DIGITS-1:0] dig_bin,
    output logic [NUM_DIGITS-1:0]   dig_neg,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int BD = BCD_DIGITS(WIDTH);
    localparam int HD = HEX_DIGITS(WIDTH);
    localparam int SD = (BD > HD) ? BD : HD;
    // Source digit vector is at least as wide as the display so every digit index is in range.
    localparam int SW = (SD > NUM_DIGITS) ? SD : NUM_DIGITS;

    state_t state_q, state_d;

    logic             capture;
    logic             conv_load;
    logic             conv_shift;
    logic             last_bit;
    logic             dec_q;
    logic             neg_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] mag;
    logic [4*BD-1:0]  bcd;

    logic [4*SW-1:0]         src;
    int                      sig;
    logic                    fmt_ovf;
    logic [4*NUM_DIGITS-1:0] fmt_bin;
    logic [NUM_DIGITS-1:0]   fmt_en;
    logic [NUM_DIGITS-1:0]   fmt_neg;

    logic                    done_q;
    logic                    ovf_q;
    logic [4*NUM_DIGITS-1:0] bin_q;
    logic [NUM_DIGITS-1:0]   neg_out_q;
    logic [NUM_DIGITS-1:0]   en_q;

    // Most negative input negates to itself, which reads correctly as the unsigned magnitude.
    assign mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

    sseg_bin2bcd_serial #(
        .WIDTH (WIDTH),
        .BD    (BD)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (conv_load),
        .shift    (conv_shift),
        .bin_in   (mag),
        .bcd      (bcd),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        conv_load  = 1'b0;
        conv_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    if (mode_dec) begin
                        conv_load = 1'b1;
                        state_d   = CONV;
                    end else begin
                        state_d   = FMT;
                    end
                end
            end
            CONV: begin
                conv_shift = 1'b1;
                if (last_bit) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= 1'b0;
            neg_q   <= 1'b0;
            value_q <= '0;
        end else if (capture) begin
            dec_q   <= mode_dec;
            neg_q   <= mode_dec & value[WIDTH-1];
            value_q <= value;
        end
    end

    always_comb begin
        src = '0;
        if (dec_q) begin
            src[4*BD-1:0] = bcd;
        end else begin
            src[WIDTH-1:0] = value_q;
        end

        sig = 1;
        for (int i = 0; i < SW; i++) begin
            if (src[4*i +: 4] != 4'd0) begin
                sig = i + 1;
            end
        end

        fmt_ovf = (sig > NUM_DIGITS) || (neg_q && (sig == NUM_DIGITS));

        fmt_bin = '0;
        fmt_en  = '0;
        fmt_neg = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (fmt_ovf) begin
                fmt_en[i]  = 1'b1;
                fmt_neg[i] = 1'b1;
            end else if (i < sig) begin
                fmt_en[i]         = 1'b1;
                fmt_bin[4*i +: 4] = src[4*i +: 4];
            end else if ((i == sig) && neg_q) begin
                fmt_en[i]  = 1'b1;
                fmt_neg[i] = 1'b1;
            end
        end
    end

    // Display registers only load in FMT so the digits hold steady during a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bin_q     <= '0;
            neg_out_q <= '0;
            en_q      <= '0;
        end else begin
            done_q <= (state_q == FMT);
            if (state_q == FMT) begin
                ovf_q     <= fmt_ovf;
                bin_q     <= fmt_bin;
                neg_out_q <= fmt_neg;
                en_q      <= fmt_en;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign dig_bin = bin_q;
    assign dig_neg = neg_out_q;
    assign dig_en  = en_q;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// tb/tb_sseg_display_ctrl.sv - self-checking bench for sseg_display_ctrl against a digit-arithmetic model
module tb_sseg_display_ctrl;

    localparam int ND = 4;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode_dec;
    logic [W-1:0]  value;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [4*ND-1:0] dig_bin;
    logic [ND-1:0] dig_neg;
    logic [ND-1:0] dig_en;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    sseg_display_ctrl #(
        .NUM_DIGITS (ND),
        .WIDTH      (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode_dec (mode_dec),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .dig_bin  (dig_bin),
        .dig_neg  (dig_neg),
        .dig_en   (dig_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected display from plain radix arithmetic on the captured value.
    function automatic void calc(input logic dec, input logic [W-1:0] v,
                                 output logic [4*ND-1:0] eb, output logic [ND-1:0] een,
                                 output logic [ND-1:0] eng, output logic eo);
        int mag;
        int base;
        int n;
        bit neg;
        int digs[8];
        neg  = dec && v[W-1];
        mag  = int'(v);
        if (neg) mag = (1 << W) - mag;
        base = dec ? 10 : 16;
        n = 0;
        do begin
            digs[n] = mag % base;
            mag     = mag / base;
            n++;
        end while (mag > 0);
        eo  = (n > ND) || (neg && n == ND);
        eb  = '0;
        een = '0;
        eng = '0;
        for (int i = 0; i < ND; i++) begin
            if (eo) begin
                een[i] = 1'b1;
                eng[i] = 1'b1;
            end else if (i < n) begin
                een[i]       = 1'b1;
                eb[4*i +: 4] = 4'(digs[i]);
            end else if (i == n && neg) begin
                een[i] = 1'b1;
                eng[i] = 1'b1;
            end
        end
    endfunction

    // Model: a countdown of cycles left until done, plus the last displayed result.
    int              m_cnt;
    logic            m_dec;
    logic [W-1:0]    m_val;
    logic            m_done;
    logic            m_ovf;
    logic [4*ND-1:0] m_bin;
    logic [ND-1:0]   m_en;
    logic [ND-1:0]   m_neg;
    logic [4*ND-1:0] t_bin;
    logic [ND-1:0]   t_en;
    logic [ND-1:0]   t_neg;
    logic            t_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_bin  <= '0;
            m_en   <= '0;
            m_neg  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt <= mode_dec ? W + 1 : 1;
                    m_dec <= mode_dec;
                    m_val <= value;
                end
            end else begin
                if (m_cnt == 1) begin
                    calc(m_dec, m_val, t_bin, t_en, t_neg, t_ovf);
                    m_done <= 1'b1;
                    m_bin  <= t_bin;
                    m_en   <= t_en;
                    m_neg  <= t_neg;
                    m_ovf  <= t_ovf;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (m_cnt != 0));
            chk("done", done, m_done);
            chk("ovf", ovf, m_ovf);
            chk("dig_bin", dig_bin, m_bin);
            chk("dig_en", dig_en, m_en);
            chk("dig_neg", dig_neg, m_neg);
        end
    end

    task automatic do_op(input logic dec, input logic [W-1:0] val, output int lat);
        @(negedge clk);
        mode_dec = dec;
        value    = val;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        value    = W'($urandom);
        mode_dec = ~dec;
        lat      = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int pulses;
    int hex_lat;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        mode_dec = 1'b1;
        value    = 12'd123;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_en", dig_en, 0);
        chk("rst_neg", dig_neg, 0);
        chk("rst_bin", dig_bin, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_en", dig_en, 0);

        do_op(1'b1, 12'd123, lat);
        chk("dec123_lat", lat, 14);
        chk("dec123_en", dig_en, 4'b0111);
        chk("dec123_bin", dig_bin, 16'h0123);
        chk("dec123_neg", dig_neg, 4'b0000);
        chk("dec123_ovf", ovf, 0);

        do_op(1'b1, 12'(-45), lat);
        chk("decm45_en", dig_en, 4'b0111);
        chk("decm45_neg", dig_neg, 4'b0100);
        chk("decm45_bin", dig_bin[7:0], 8'h45);

        do_op(1'b1, 12'(-999), lat);
        chk("decm999_en", dig_en, 4'b1111);
        chk("decm999_neg", dig_neg, 4'b1000);
        chk("decm999_bin", dig_bin[11:0], 12'h999);

        do_op(1'b1, 12'd2047, lat);
        chk("dec2047_en", dig_en, 4'b1111);
        chk("dec2047_bin", dig_bin, 16'h2047);
        chk("dec2047_ovf", ovf, 0);

        do_op(1'b1, 12'h800, lat);
        chk("decm2048_ovf", ovf, 1);
        chk("decm2048_en", dig_en, 4'b1111);
        chk("decm2048_neg", dig_neg, 4'b1111);
        chk("decm2048_bin", dig_bin, 16'h0000);

        do_op(1'b1, 12'd0, lat);
        chk("dec0_ovf", ovf, 0);
        chk("dec0_en", dig_en, 4'b0001);
        chk("dec0_bin", dig_bin, 16'h0000);

        // Hex with a second start during busy that must be dropped.
        @(negedge clk);
        mode_dec = 1'b0;
        value    = 12'hABC;
        start    = 1'b1;
        pulses   = 0;
        hex_lat  = 0;
        @(negedge clk);
        value    = 12'h123;
        start    = 1'b1;
        if (done === 1'b1) pulses++;
        @(negedge clk);
        start = 1'b0;
        if (done === 1'b1) begin
            pulses++;
            hex_lat = 2;
            chk("hexabc_en", dig_en, 4'b0111);
            chk("hexabc_bin", dig_bin, 16'h0ABC);
            chk("hexabc_neg", dig_neg, 4'b0000);
        end
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("hex_lat", hex_lat, 2);
        chk("hex_pulses", pulses, 1);

        // Reset in the middle of a decimal conversion.
        do_op(1'b1, 12'd123, lat);
        @(negedge clk);
        mode_dec = 1'b1;
        value    = 12'd456;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_en", dig_en, 0);
        chk("abort_neg", dig_neg, 0);
        chk("abort_bin", dig_bin, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_idle", busy, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            mode_dec = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       value = 12'd0;
                1:       value = 12'h800;
                2:       value = 12'h7FF;
                3:       value = 12'hFFF;
                default: value = W'($urandom);
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
